counter_sequencer: RTL and testbench

COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

---
 rtl/counter_sequencer.sv | 122 ++++++++++++
 tb/tb_counter_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// Sequencer that drives an external loadable up-counter through LOAD/RUN/DONE and emits terminal ticks.
// Optional saturating tick counter output enabled by defining COUNTER_SEQUENCER_TICKCNT_EN.
module counter_sequencer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         mode,
  input  logic [N-1:0] period,
  input  logic [N-1:0] cnt_q,
  output logic [N-1:0] cnt_d,
  output logic         cnt_load,
  output logic         cnt_en,
  output logic         busy,
  output logic         tick,
  output logic         done,
`ifdef COUNTER_SEQUENCER_TICKCNT_EN
  output logic [7:0]   tick_cnt,
`endif
  output logic         err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t       state_q, state_d;
  logic [N-1:0] period_r_q, period_r_d;
  logic         mode_r_q, mode_r_d;
  logic         err_q, err_d;
  logic         terminal;

  // period_r is never 0 in RUN, so the N-bit subtract cannot wrap there
  assign terminal = (cnt_q == (period_r_q - ONE));

  always_comb begin
    state_d    = state_q;
    period_r_d = period_r_q;
    mode_r_d   = mode_r_q;
    err_d      = 1'b0;
    tick       = 1'b0;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    done       = 1'b0;
    if (stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (period != '0) begin
              period_r_d = period;
              mode_r_d   = mode;
              state_d    = S_LOAD;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_LOAD: begin
          cnt_load = 1'b1;
          state_d  = S_RUN;
        end
        S_RUN: begin
          if (terminal) begin
            tick = 1'b1;
            if (mode_r_q) cnt_load = 1'b1;
            else          state_d  = S_DONE;
          end else begin
            cnt_en = 1'b1;
          end
        end
        S_DONE: begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      period_r_q <= '0;
      mode_r_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      period_r_q <= period_r_d;
      mode_r_q   <= mode_r_d;
      err_q      <= err_d;
    end
  end

  assign cnt_d = '0;
  assign busy  = (state_q != S_IDLE);
  assign err   = err_q;

`ifdef COUNTER_SEQUENCER_TICKCNT_EN
  logic [7:0] tick_cnt_q, tick_cnt_d;
  logic       accept;

  assign accept = (state_q == S_IDLE) && start && !stop && (period != '0);

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (accept)                           tick_cnt_d = '0;
    else if (tick && tick_cnt_q != 8'hff) tick_cnt_d = tick_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tick_cnt_q <= '0;
    else        tick_cnt_q <= tick_cnt_d;
  end

  assign tick_cnt = tick_cnt_q;
`endif

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer (N=4) with a loadable up-counter model attached.
module tb_counter_sequencer;
  localparam int N = 4;

  logic         clk, reset, start, stop, mode;
  logic [N-1:0] period, cnt_q, cnt_d;
  logic         cnt_load, cnt_en, busy, tick, done, err;
`ifdef COUNTER_SEQUENCER_TICKCNT_EN
  logic [7:0]   tick_cnt;
`endif

  int checks = 0;
  int fails  = 0;

  counter_sequencer #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
    .period(period), .cnt_q(cnt_q), .cnt_d(cnt_d), .cnt_load(cnt_load),
    .cnt_en(cnt_en), .busy(busy), .tick(tick), .done(done),
`ifdef COUNTER_SEQUENCER_TICKCNT_EN
    .tick_cnt(tick_cnt),
`endif
    .err(err)
  );

  // external loadable up-counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        cnt_q <= '0;
    else if (cnt_load) cnt_q <= cnt_d;
    else if (cnt_en)   cnt_q <= cnt_q + 4'd1;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_cnt_d"}, 32'(cnt_d), 0);
    chk({tag, "_load"}, 32'(cnt_load), 0);
    chk({tag, "_en"}, 32'(cnt_en), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_tick"}, 32'(tick), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  // present a start in the current cycle (cycle 0); returns in cycle 1 with
  // period/mode scrambled to show they are not sampled outside IDLE
  task automatic kick(input logic m, input logic [N-1:0] p);
    start = 1'b1; mode = m; period = p;
    next_cyc();
    start = 1'b0; mode = ~m; period = 4'd9;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; period = '0;
    #12;
    all_zero("rst");
`ifdef COUNTER_SEQUENCER_TICKCNT_EN
    chk("rst_tcnt", 32'(tick_cnt), 0);
`endif
    // start presented together with reset release: taken at the first edge
    @(negedge clk);
    reset = 1'b1; start = 1'b1; mode = 1'b0; period = 4'd2;
    next_cyc();
    start = 1'b0;
    chk("first_busy", 32'(busy), 1);
    chk("first_load", 32'(cnt_load), 1);
    next_cyc(); next_cyc();
    chk("first_tick", 32'(tick), 1);
    chk("first_cnt", 32'(cnt_q), 1);
    next_cyc();
    chk("first_done", 32'(done), 1);
    next_cyc();
    chk("first_idle", 32'(busy), 0);

    // one-shot period=5
    kick(1'b0, 4'd5);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk($sformatf("os5_busy_c%0d", c), 32'(busy), 32'(c >= 1 && c <= 7));
      chk($sformatf("os5_tick_c%0d", c), 32'(tick), 32'(c == 6));
      chk($sformatf("os5_done_c%0d", c), 32'(done), 32'(c == 7));
      chk($sformatf("os5_load_c%0d", c), 32'(cnt_load), 32'(c == 1));
      if (c >= 2 && c <= 6) chk($sformatf("os5_cnt_c%0d", c), 32'(cnt_q), 32'(c - 2));
      next_cyc();
    end

    // periodic period=3
    kick(1'b1, 4'd3);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      chk($sformatf("p3_tick_c%0d", c), 32'(tick), 32'(c >= 4 && (c - 4) % 3 == 0));
      chk($sformatf("p3_load_c%0d", c), 32'(cnt_load), 32'(c == 1 || (c >= 4 && (c - 4) % 3 == 0)));
      if (c >= 2) chk($sformatf("p3_cnt_c%0d", c), 32'(cnt_q), 32'((c - 2) % 3));
      next_cyc();
    end
    stop = 1'b1;
    @(negedge clk);
    chk("p3_stop_en", 32'(cnt_en), 0);
    chk("p3_stop_busy", 32'(busy), 1);
    next_cyc();
    stop = 1'b0;
    chk("p3_idle", 32'(busy), 0);

    // periodic period=1
    kick(1'b1, 4'd1);
    next_cyc();
    for (int c = 2; c <= 6; c++) begin
      @(negedge clk);
      chk($sformatf("p1_tick_c%0d", c), 32'(tick), 1);
      chk($sformatf("p1_cnt_c%0d", c), 32'(cnt_q), 0);
      chk($sformatf("p1_load_c%0d", c), 32'(cnt_load), 1);
      next_cyc();
    end
    stop = 1'b1;
    @(negedge clk);
    chk("p1_stop_tick", 32'(tick), 0);
    chk("p1_stop_load", 32'(cnt_load), 0);
    next_cyc();
    stop = 1'b0;

    // period=0 rejected
    kick(1'b0, 4'd0);
    @(negedge clk);
    chk("p0_err", 32'(err), 1);
    chk("p0_busy", 32'(busy), 0);
    chk("p0_load", 32'(cnt_load), 0);
    next_cyc();
    chk("p0_err_clr", 32'(err), 0);

    // stop beats start
    start = 1'b1; stop = 1'b1; period = 4'd5;
    next_cyc();
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", 32'(busy), 0);
    chk("ss_err", 32'(err), 0);

    // periodic 15, start in cycle 5 ignored, stop in cycle 8
    kick(1'b1, 4'd15);
    for (int c = 1; c <= 9; c++) begin
      start = (c == 5); stop = (c == 8);
      if (c == 5) begin mode = 1'b0; period = 4'd2; end
      @(negedge clk);
      if (c == 7) begin
        chk("abort_cnt7", 32'(cnt_q), 5);
        chk("abort_en7", 32'(cnt_en), 1);
      end
      if (c == 8) begin
        chk("abort_cnt8", 32'(cnt_q), 6);
        chk("abort_tick8", 32'(tick), 0);
        chk("abort_en8", 32'(cnt_en), 0);
        chk("abort_load8", 32'(cnt_load), 0);
      end
      if (c == 9) chk("abort_idle9", 32'(busy), 0);
      next_cyc();
    end
    start = 1'b0; stop = 1'b0;

    // one-shot 15: terminal at 14, no wrap
    kick(1'b0, 4'd15);
    repeat (15) next_cyc();
    @(negedge clk);
    chk("os15_cnt", 32'(cnt_q), 14);
    chk("os15_tick", 32'(tick), 1);
    chk("os15_en", 32'(cnt_en), 0);
    next_cyc();
    chk("os15_done", 32'(done), 1);
    next_cyc();

    // async reset mid-RUN at cnt_q=3
    kick(1'b1, 4'd10);
    repeat (4) next_cyc();
    chk("mr_cnt", 32'(cnt_q), 3);
    chk("mr_en", 32'(cnt_en), 1);
    #1 reset = 1'b0;
    #1 all_zero("mr");
    @(negedge clk);
    reset = 1'b1;

`ifdef COUNTER_SEQUENCER_TICKCNT_EN
    next_cyc();
    kick(1'b1, 4'd1);
    for (int c = 1; c <= 305; c++) begin
      if (c == 102) chk("tc_100", 32'(tick_cnt), 100);
      next_cyc();
    end
    chk("tc_sat", 32'(tick_cnt), 255);
    stop = 1'b1;
    next_cyc();
    stop = 1'b0;
    chk("tc_hold", 32'(tick_cnt), 255);
    kick(1'b0, 4'd3);
    chk("tc_clr", 32'(tick_cnt), 0);
    repeat (4) next_cyc();
    chk("tc_one", 32'(tick_cnt), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
